lookup3_unmix: RTL and testbench
================================

Name: lookup3_unmix

Overview:
- Inverse of the lookup3 mix core: takes a mixed (a,b,c) triple and runs the six mix rounds backwards, one round per cycle, to recover the pre-mix triple.
- Used as the decode or self-check end of the jhash datapath. Results are compared against captured keys for hash-core verification and key recovery in debug.
- Iterative: one shared round datapath with rotating register roles; valid/ready handshake on both sides.

Parameters:
- INITVAL, 32'hdeadbeef, seed constant used when computing the init value (feature only).

Ports:
- clk        input   1   clock
- rst        input   1   synchronous active-high reset
- in_valid   input   1   mixed triple present
- in_ready   output  1   block idle, can accept
- ia         input   32  mixed a
- ib         input   32  mixed b
- ic         input   32  mixed c
- length     input   32  key length in words; sampled with the triple; used only with the feature
- out_valid  output  1   result available
- out_ready  input   1   consumer takes result
- oa         output  32  recovered a (or k0)
- ob         output  32  recovered b (or k1)
- oc         output  32  recovered c (or k2)

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high.
- Reset values: state IDLE; in_ready=1; out_valid=0; oa/ob/oc=0; round counter 5.
- Arithmetic: all modulo 2^32. rot(v,s) = (v<<s)|(v>>(32-s)).
- Forward round r applies x-=z; x^=rot(z,s); z+=y.
  - Shift table s[0..5] = 4,6,8,16,19,4.
  - Roles (x,y,z) for r mod 3: 0→(a,b,c), 1→(b,c,a), 2→(c,a,b).
- Inverse round r (same roles and shift): z-=y; x^=rot(z,s); x+=z. Only x and z change.
- FSM:
  - IDLE: in_ready=1. On in_valid, load a/b/c from ia/ib/ic, capture length, set r=5, go to RUN.
  - RUN: apply inverse round r each cycle, r decrements 5→0. After r=0, go to FIX if the feature is compiled in, else DONE.
  - FIX (feature only): one cycle, subtract init value from a, b and c; go to DONE.
  - DONE: out_valid=1, oa/ob/oc hold the result stable. On out_ready, go to IDLE with out_valid=0 the next cycle.
- Latency: accept edge at cycle T → out_valid high at T+7 (T+8 with feature).
- Throughput: one triple per 8 cycles (9 with feature) when out_ready is held high.
- in_ready is low in RUN, FIX and DONE; in_valid is ignored there. No input skid buffer.
- out_valid stays high until out_ready; there is no timeout.
- rst asserted in any state aborts the operation and restores all reset values on the next edge.
- rst and in_valid in the same cycle: rst wins, nothing is accepted.

Optional Feature:
- Macro LOOKUP3_UNMIX_INIT_EN.
- When defined: adds the FIX state. Init value iv = (length<<2) + INITVAL (32-bit wrap). Outputs are oa-iv, ob-iv, oc-iv, giving the original k0,k1,k2 as fed to the hash core.
- When undefined: no FIX state; length is unused; outputs are the raw pre-mix triple.

Decomposition:
- Shared package lookup3_pkg: state enum (IDLE, RUN, FIX, DONE), shift table constants, INITVAL default, rot function.
- Sub-module unmix_round: combinational; inputs x, y, z, shift; outputs x', y (pass-through), z'.
- Top module holds the FSM, round counter and role steering.

Test Plan:
- Zero triple, feature off: ia=ib=ic=0 → oa=ob=oc=0 with out_valid at T+7.
- Zero triple, feature on, length=0: ia=ib=ic=0 → oa=ob=oc=32'h21524111 at T+8.
- Round trip: golden C forward mix of (1,2,3), then (32'hdeadbeef,0,32'hffffffff), then 100 random triples fed in → outputs equal the original triples exactly.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid → out_valid and outputs stable, in_ready=0 throughout. Release → one-cycle transfer, then in_ready=1.
- Reset mid-run: assert rst at round 2 → next edge out_valid=0, outputs 0, in_ready=1. A fresh triple then completes correctly.
- Back-to-back: in_valid and out_ready held high with 4 queued triples → exactly 4 results, in order, spaced 8 cycles apart (feature off).

Source files
------------

// File: rtl/lookup3_pkg.sv
// ---------------------------------------------------------------------------
// lookup3_pkg
//
// Shared definitions for the lookup3 unmix datapath:
//   - state_e   : FSM states of the iterative unmix engine
//   - role_e    : which of a/b/c play the x/y/z roles in a given round
//   - triple_t  : packed (a,b,c) word triple
//   - INITVAL_DEFAULT : default jhash seed constant
//   - shift_of(): per-round rotate amount (4,6,8,16,19,4)
//   - role_of() : per-round role assignment (round mod 3)
//   - rot()     : 32-bit rotate-left
// ---------------------------------------------------------------------------
package lookup3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX,
    ST_DONE
  } state_e;

  // Role assignment (x, y, z) used by a round.
  typedef enum logic [1:0] {
    ROLE_ABC,  // x=a, y=b, z=c
    ROLE_BCA,  // x=b, y=c, z=a
    ROLE_CAB   // x=c, y=a, z=b
  } role_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } triple_t;

  localparam logic [31:0] INITVAL_DEFAULT = 32'hdeadbeef;
  localparam logic [2:0]  LAST_ROUND      = 3'd5;

  // Rotate amounts of the six forward mix rounds.
  localparam logic [4:0] SHIFT_R0 = 5'd4;
  localparam logic [4:0] SHIFT_R1 = 5'd6;
  localparam logic [4:0] SHIFT_R2 = 5'd8;
  localparam logic [4:0] SHIFT_R3 = 5'd16;
  localparam logic [4:0] SHIFT_R4 = 5'd19;
  localparam logic [4:0] SHIFT_R5 = 5'd4;

  function automatic logic [4:0] shift_of(input logic [2:0] r);
    logic [4:0] s;
    case (r)
      3'd0:    s = SHIFT_R0;
      3'd1:    s = SHIFT_R1;
      3'd2:    s = SHIFT_R2;
      3'd3:    s = SHIFT_R3;
      3'd4:    s = SHIFT_R4;
      3'd5:    s = SHIFT_R5;
      default: s = SHIFT_R0;
    endcase
    return s;
  endfunction

  // Roles repeat with period 3 across the six rounds.
  function automatic role_e role_of(input logic [2:0] r);
    role_e ro;
    case (r)
      3'd0, 3'd3: ro = ROLE_ABC;
      3'd1, 3'd4: ro = ROLE_BCA;
      3'd2, 3'd5: ro = ROLE_CAB;
      default:    ro = ROLE_ABC;
    endcase
    return ro;
  endfunction

  function automatic logic [31:0] rot(input logic [31:0] v, input logic [4:0] s);
    return (v << s) | (v >> (6'd32 - {1'b0, s}));
  endfunction

endpackage

// File: rtl/lookup3_unmix_round.sv
// ---------------------------------------------------------------------------
// unmix_round
//
// One inverse lookup3 mix round, purely combinational. Undoes the forward
// round  x -= z; x ^= rot(z,s); z += y  by applying
//        z -= y; x ^= rot(z,s); x += z.
// y is never modified by a round and is passed straight through.
//
// Ports:
//   x_i, y_i, z_i : 32-bit round inputs in role order
//   shift_i       : rotate amount of this round
//   x_o, y_o, z_o : 32-bit round outputs in role order
// ---------------------------------------------------------------------------
module unmix_round
  import lookup3_pkg::*;
(
  input  logic [31:0] x_i,
  input  logic [31:0] y_i,
  input  logic [31:0] z_i,
  input  logic [4:0]  shift_i,
  output logic [31:0] x_o,
  output logic [31:0] y_o,
  output logic [31:0] z_o
);

  logic [31:0] z_prev;

  // Recover z first: the forward round's xor/sub on x used the old z.
  assign z_prev = z_i - y_i;
  assign z_o    = z_prev;
  assign x_o    = (x_i ^ rot(z_prev, shift_i)) + z_prev;
  assign y_o    = y_i;

endmodule

// File: rtl/lookup3_unmix.sv
// ---------------------------------------------------------------------------
// lookup3_unmix
//
// Iterative inverse of the lookup3 mix core. Accepts a mixed (a,b,c) triple,
// runs the six mix rounds backwards (round 5 down to 0), one per cycle, on a
// single shared round datapath whose x/y/z roles rotate over a/b/c, and
// presents the recovered pre-mix triple.
//
// Optional feature, macro LOOKUP3_UNMIX_INIT_EN:
//   adds a FIX cycle subtracting iv = (length<<2) + INITVAL from each word,
//   so the outputs are the original key words k0,k1,k2.
//
// Parameters:
//   INITVAL   : jhash seed constant (used only with the feature)
//
// Ports:
//   clk       : clock
//   rst       : synchronous active-high reset
//   in_valid  : mixed triple present       in_ready : idle, can accept
//   ia/ib/ic  : mixed a/b/c                length   : key length in words
//   out_valid : result available           out_ready: consumer takes result
//   oa/ob/oc  : recovered a/b/c (or k0/k1/k2)
// ---------------------------------------------------------------------------
module lookup3_unmix
  import lookup3_pkg::*;
#(
  parameter logic [31:0] INITVAL = INITVAL_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] ia,
  input  logic [31:0] ib,
  input  logic [31:0] ic,
  input  logic [31:0] length,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] oa,
  output logic [31:0] ob,
  output logic [31:0] oc
);

  state_e      state_q, state_d;
  logic [2:0]  round_q, round_d;
  triple_t     work_q,  work_d;   // working triple being unmixed
  triple_t     res_q,   res_d;    // result held stable for the consumer

  logic [31:0] rx, ry, rz;        // round inputs in role order
  logic [31:0] rx_n, ry_n, rz_n;  // round outputs in role order
  logic [4:0]  round_shift;
  role_e       round_role;

`ifdef LOOKUP3_UNMIX_INIT_EN
  logic [31:0] len_q, len_d;
  logic [31:0] init_val;

  assign init_val = (len_q << 2) + INITVAL;
`else
  // length and INITVAL only matter for the init-value correction.
  logic unused_cfg;
  assign unused_cfg = ^{length, INITVAL};
`endif

  assign round_shift = shift_of(round_q);
  assign round_role  = role_of(round_q);

  // Steer a/b/c into the x/y/z roles of the current round.
  always_comb begin
    rx = work_q.a;
    ry = work_q.b;
    rz = work_q.c;
    case (round_role)
      ROLE_BCA: begin
        rx = work_q.b;
        ry = work_q.c;
        rz = work_q.a;
      end
      ROLE_CAB: begin
        rx = work_q.c;
        ry = work_q.a;
        rz = work_q.b;
      end
      default: ;
    endcase
  end

  unmix_round u_round (
    .x_i     (rx),
    .y_i     (ry),
    .z_i     (rz),
    .shift_i (round_shift),
    .x_o     (rx_n),
    .y_o     (ry_n),
    .z_o     (rz_n)
  );

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case statement leaves one unassigned, which would infer a latch.
    state_d = state_q;
    round_d = round_q;
    work_d  = work_q;
    res_d   = res_q;
`ifdef LOOKUP3_UNMIX_INIT_EN
    len_d   = len_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          work_d  = '{a: ia, b: ib, c: ic};
          round_d = LAST_ROUND;
`ifdef LOOKUP3_UNMIX_INIT_EN
          len_d   = length;
`endif
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // Map the round outputs back from roles to a/b/c.
        case (round_role)
          ROLE_BCA: work_d = '{a: rz_n, b: rx_n, c: ry_n};
          ROLE_CAB: work_d = '{a: ry_n, b: rz_n, c: rx_n};
          default:  work_d = '{a: rx_n, b: ry_n, c: rz_n};
        endcase
        if (round_q == 3'd0) begin
`ifdef LOOKUP3_UNMIX_INIT_EN
          state_d = ST_FIX;
`else
          state_d = ST_DONE;
`endif
        end else begin
          round_d = round_q - 3'd1;
        end
      end

`ifdef LOOKUP3_UNMIX_INIT_EN
      ST_FIX: begin
        work_d  = '{a: work_q.a - init_val,
                    b: work_q.b - init_val,
                    c: work_q.c - init_val};
        state_d = ST_DONE;
      end
`endif

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Capture the result once, on entry to DONE, so it stays stable while
    // the consumer stalls.
    if (state_d == ST_DONE && state_q != ST_DONE) begin
      res_d = work_d;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: the datapath registers are reset too, so an aborted operation
      // never leaves a stale partial result on oa/ob/oc.
      state_q <= ST_IDLE;
      round_q <= LAST_ROUND;
      work_q  <= '0;
      res_q   <= '0;
`ifdef LOOKUP3_UNMIX_INIT_EN
      len_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      work_q  <= work_d;
      res_q   <= res_d;
`ifdef LOOKUP3_UNMIX_INIT_EN
      len_q   <= len_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign oa        = res_q.a;
  assign ob        = res_q.b;
  assign oc        = res_q.c;

endmodule

// File: tb/tb_lookup3_unmix.sv
// ---------------------------------------------------------------------------
// tb_lookup3_unmix
//
// Self-checking bench for lookup3_unmix. Mixed inputs are produced with the
// forward lookup3 mix written out as in the reference C code; the expected
// DUT output is the key triple that was mixed. A scoreboard queue is filled
// on every accepted handshake and drained by one compare process that checks
// in_ready, latency and the output triple on every falling clock edge.
// Builds with or without LOOKUP3_UNMIX_INIT_EN.
// ---------------------------------------------------------------------------
module tb_lookup3_unmix;

`ifdef LOOKUP3_UNMIX_INIT_EN
  localparam int          LAT      = 8;
  localparam logic [95:0] ZERO_EXP = {3{32'h21524111}};
`else
  localparam int          LAT      = 7;
  localparam logic [95:0] ZERO_EXP = '0;
`endif
  localparam int PERIOD = LAT + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ia, ib, ic, length;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] oa, ob, oc;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_results = 0;

  typedef struct {
    logic [95:0] exp_v;
    int          acc_c;
  } item_t;

  item_t       sb_q[$];
  bit          front_seen = 1'b0;
  logic [95:0] exp_pending;

  lookup3_unmix dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ia        (ia),
    .ib        (ib),
    .ic        (ic),
    .length    (length),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .oa        (oa),
    .ob        (ob),
    .oc        (oc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] v, input int s);
    return (v << s) | (v >> (32 - s));
  endfunction

  // Forward lookup3 mix, first n rounds, as in the reference C.
  function automatic logic [95:0] mix_n(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input int n);
    if (n > 0) begin a -= c; a ^= rotl(c, 4);  c += b; end
    if (n > 1) begin b -= a; b ^= rotl(a, 6);  a += c; end
    if (n > 2) begin c -= b; c ^= rotl(b, 8);  b += a; end
    if (n > 3) begin a -= c; a ^= rotl(c, 16); c += b; end
    if (n > 4) begin b -= a; b ^= rotl(a, 19); a += c; end
    if (n > 5) begin c -= b; c ^= rotl(b, 4);  b += a; end
    return {a, b, c};
  endfunction

  function automatic logic [31:0] iv_of(input logic [31:0] len);
`ifdef LOOKUP3_UNMIX_INIT_EN
    return (len << 2) + 32'hdeadbeef;
`else
    return 32'd0 & len;
`endif
  endfunction

  // Mixed triple whose recovery by the DUT must give back key k.
  function automatic logic [95:0] premix(input logic [95:0] k, input logic [31:0] len);
    logic [31:0] iv;
    iv = iv_of(len);
    return mix_n(k[95:64] + iv, k[63:32] + iv, k[31:0] + iv, 6);
  endfunction

  // Single compare process: scoreboard push on accept, check/pop on output.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      front_seen = 1'b0;
    end else begin
      check("in_ready", 96'(in_ready), 96'(sb_q.size() == 0));
      if (sb_q.size() == 0) begin
        check("out_valid_idle", 96'(out_valid), 96'd0);
      end else if (out_valid) begin
        if (!front_seen) begin
          check("latency", 96'(cyc - sb_q[0].acc_c), 96'(LAT));
          front_seen = 1'b1;
        end
        check("result", {oa, ob, oc}, sb_q[0].exp_v);
        if (out_ready) begin
          void'(sb_q.pop_front());
          front_seen = 1'b0;
          n_results++;
        end
      end
      if (in_valid && in_ready) sb_q.push_back('{exp_v: exp_pending, acc_c: cyc});
    end
  end

  task automatic send(input logic [95:0] in_t, input logic [31:0] len,
                      input logic [95:0] exp, output int acc);
    bit ok;
    ok  = 1'b0;
    acc = -1;
    {ia, ib, ic} = in_t;
    length       = len;
    exp_pending  = exp;
    in_valid     = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready && !rst) begin
        ok  = 1'b1;
        acc = cyc;
        break;
      end
    end
    check("accepted", 96'(ok), 96'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_key(input logic [95:0] k, input logic [31:0] len, output int acc);
    send(premix(k, len), len, k, acc);
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    check("drained", 96'(done), 96'd1);
  endtask

  initial begin
    int          acc;
    int          acc4[4];
    int          base;
    bit          seen;
    logic [95:0] k;
    logic [31:0] len;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ia = '0; ib = '0; ic = '0; length = '0;
    exp_pending = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  96'(in_ready),  96'd1);
    check("rst_out_valid", 96'(out_valid), 96'd0);
    check("rst_outputs",   {oa, ob, oc},   96'd0);
    rst = 1'b0;

    // Pin the model with hand-computed values.
    check("model_zero",    mix_n(32'd0, 32'd0, 32'd0, 6), 96'd0);
    check("model_2rounds", mix_n(32'd1, 32'd2, 32'd3, 2),
          {32'hffffffd3, 32'hfffff38b, 32'h00000005});

    // Zero triple, length 0: raw zeros, or -INITVAL per word with the feature.
    send(96'd0, 32'd0, ZERO_EXP, acc);
    wait_drain();

    // Directed round trips.
    send_key({32'd1, 32'd2, 32'd3}, 32'd3, acc);
    wait_drain();
    send_key({32'hdeadbeef, 32'h0, 32'hffffffff}, 32'd0, acc);
    wait_drain();
    send_key({32'hffffffff, 32'hffffffff, 32'hffffffff}, 32'hffffffff, acc);
    wait_drain();

    // Random round trips, issued as fast as the DUT accepts.
    for (int i = 0; i < 100; i++) begin
      k   = {$urandom(), $urandom(), $urandom()};
      len = $urandom_range(0, 255);
      send_key(k, len, acc);
    end
    wait_drain();

    // Backpressure: result must hold while out_ready is low; new input ignored.
    out_ready = 1'b0;
    send_key({32'h01234567, 32'h89abcdef, 32'h0badf00d}, 32'd5, acc);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("bp_out_valid_seen", 96'(seen), 96'd1);
    in_valid = 1'b1;
    ia = 32'h55555555; ib = 32'haaaaaaaa; ic = 32'h12345678;
    exp_pending = '0;
    repeat (20) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid",    96'(out_valid), 96'd1);
      check("bp_hold_in_ready", 96'(in_ready),  96'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid",    96'(out_valid), 96'd0);
    check("bp_release_in_ready", 96'(in_ready),  96'd1);

    // Reset while round 2 is pending.
    send_key({32'hcafef00d, 32'h13579bdf, 32'h2468ace0}, 32'd7, acc);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_out_valid", 96'(out_valid), 96'd0);
    check("midrst_outputs",   {oa, ob, oc},   96'd0);
    check("midrst_in_ready",  96'(in_ready),  96'd1);
    send_key({32'h0000beef, 32'hfeed0000, 32'h00c0ffee}, 32'd2, acc);
    wait_drain();

    // Back-to-back: four triples, in_valid and out_ready held high.
    base = n_results;
    for (int i = 0; i < 4; i++) begin
      k = {32'(i * 32'h11111111), 32'(32'hf0f0f0f0 ^ i), 32'(i + 32'h7)};
      send_key(k, 32'(i), acc4[i]);
    end
    for (int i = 1; i < 4; i++) begin
      check("b2b_spacing", 96'(acc4[i] - acc4[i-1]), 96'(PERIOD));
    end
    wait_drain();
    check("b2b_count", 96'(n_results - base), 96'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
